mul8_nibble_seq: RTL
====================

MUL8_NIBBLE_SEQ -- requirements
Module: mul8_nibble_seq

Interface
REQ-001 Parameters: none; all widths are fixed.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  asynchronous reset, active-high.
REQ-004 start  input  1  request a multiply; sampled only in IDLE.
REQ-005 in0  input  8  multiplicand, unsigned; captured with an accepted start.
REQ-006 in1  input  8  multiplier, unsigned; captured with an accepted start.
REQ-007 out  output  16  registered unsigned product in0*in1; holds its value until the next completion.
REQ-008 done  output  1  one-cycle pulse; out is valid and new in the same cycle.
REQ-009 busy  output  1  high whenever state is not IDLE.

Function
REQ-010 The block SHALL instantiate exactly one multiplier_4b (4x4 -> 8-bit unsigned) and reuse it once per CALC cycle; no other multiplier is permitted.
REQ-011 The FSM SHALL have states IDLE, CALC, and DONE, plus a 2-bit step counter k.
REQ-012 IDLE with start=1 at edge N: latch in0->A and in1->B, clear the 16-bit accumulator, set k=0, go to CALC.
REQ-013 IDLE with start=0: remain in IDLE; out unchanged.
REQ-014 CALC step k SHALL feed the following nibble pairs and shifts:
- k=0: A[3:0] x B[3:0], shift 0.
- k=1: A[3:0] x B[7:4], shift 4.
- k=2: A[7:4] x B[3:0], shift 4.
- k=3: A[7:4] x B[7:4], shift 8.
The shifted 8-bit partial product is added to the accumulator.
REQ-015 The CALC step SHALL occur at edges N+1..N+4; k increments each step and wraps 3->0.
REQ-016 At edge N+4 (k=3): out <= accumulator + final shifted partial; state -> DONE.
REQ-017 In the DONE state, done=1 for exactly one cycle; the next edge returns to IDLE.
REQ-018 Latency: done is high in the cycle following edge N+4; the earliest next acceptance is edge N+6, giving a throughput of one result per 6 cycles.
REQ-019 Accumulator and out SHALL be 16 bits. The maximum result is 255*255 = 0xFE01, so no overflow or truncation handling is required.
REQ-020 start SHALL be ignored in CALC and DONE; it is never queued.
REQ-021 Changes on in0/in1 after acceptance SHALL NOT affect the result in progress.
REQ-022 A held-high start SHALL be re-accepted at every IDLE edge, giving back-to-back operations.
REQ-023 done and busy SHALL be decoded from registered state only; no combinational path from start/in0/in1 to any output.

Reset
REQ-024 rst=1 SHALL immediately (asynchronously) force:
- state=IDLE, k=0;
- A, B and accumulator = 0;
- out=16'h0000, done=0, busy=0.
REQ-025 rst asserted mid-operation SHALL abandon the operation; no done is produced for it.
REQ-026 After rst deasserts, the first start is handled exactly per REQ-012.
REQ-027 While rst=1, start is ignored.

Verification
REQ-028 Max operands: reset, then start with in0=8'hFF, in1=8'hFF at edge N -> done=1 and out=16'hFE01 in the cycle after edge N+4; busy high from N through the done cycle.
REQ-029 Mixed nibbles: in0=8'h12, in1=8'h34 -> out=16'h03A8 with one done pulse; then in0=8'h80, in1=8'h02 -> out=16'h0100.
REQ-030 Zero operand: in0=8'h00, in1=8'hAB -> done still pulses and out=16'h0000.
REQ-031 Ignore while busy: accept 8'h0F x 8'h0F, then at edge N+2 drive start=1, in0=8'hFF, in1=8'hFF -> out=16'h00E1 with a single done; no second result appears.
REQ-032 Reset mid-op: assert rst during CALC k=2 -> out=0, busy=0, done=0 immediately and no done follows; after release, 8'h03 x 8'h05 -> out=16'h000F.
REQ-033 Streaming: hold start=1 with changing operands -> done pulses every 6 cycles and each out matches the operands present at its acceptance edge.

Source files
------------

// File: rtl/mul8_nibble_seq.sv
// rtl/mul8_nibble_seq.sv - 8x8 unsigned multiplier built from one reused 4x4 multiplier over four steps

// 4x4 -> 8-bit unsigned multiplier; the only multiply resource in the block.
module multiplier_4b (
   input  logic [3:0] a,
   input  logic [3:0] b,
   output logic [7:0] p
);

   assign p = a * b;

endmodule

// Sequential 8x8 multiplier: accepts operands in IDLE, accumulates four
// shifted nibble products in CALC, then pulses done for one cycle in DONE.
module mul8_nibble_seq (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [7:0]  in0,
   input  logic [7:0]  in1,
   output logic [15:0] out,
   output logic        done,
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state;
   state_t      state_next;

   logic [1:0]  k;
   logic [7:0]  a_reg;
   logic [7:0]  b_reg;
   logic [15:0] acc;

   logic [3:0]  nib_a;
   logic [3:0]  nib_b;
   logic [7:0]  partial;
   logic [15:0] partial_shifted;
   logic [15:0] sum;

   // Select the nibble pair for the current step.
   // k=1 and k=2 both carry weight 2^4, so their order does not matter.
   always_comb begin
      nib_a = a_reg[3:0];
      nib_b = b_reg[3:0];
      case (k)
         2'd0: begin
            nib_a = a_reg[3:0];
            nib_b = b_reg[3:0];
         end
         2'd1: begin
            nib_a = a_reg[3:0];
            nib_b = b_reg[7:4];
         end
         2'd2: begin
            nib_a = a_reg[7:4];
            nib_b = b_reg[3:0];
         end
         default: begin
            nib_a = a_reg[7:4];
            nib_b = b_reg[7:4];
         end
      endcase
   end

   multiplier_4b u_mul (
      .a (nib_a),
      .b (nib_b),
      .p (partial)
   );

   // Place the 8-bit partial product at the weight of its nibble pair.
   always_comb begin
      partial_shifted = {8'h00, partial};
      case (k)
         2'd0:    partial_shifted = {8'h00, partial};
         2'd1,
         2'd2:    partial_shifted = {4'h0, partial, 4'h0};
         default: partial_shifted = {partial, 8'h00};
      endcase
   end

   // 255*255 fits in 16 bits, so the running sum never overflows.
   assign sum = acc + partial_shifted;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic; start only matters in IDLE and is never queued.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (start) begin
               state_next = CALC;
            end
         end
         CALC: begin
            if (k == 2'd3) begin
               state_next = DONE;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Operand capture, step counter, accumulator and result register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_reg <= 8'h00;
         b_reg <= 8'h00;
         acc   <= 16'h0000;
         k     <= 2'd0;
         out   <= 16'h0000;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_reg <= in0;
                  b_reg <= in1;
                  acc   <= 16'h0000;
                  k     <= 2'd0;
               end
            end
            CALC: begin
               acc <= sum;
               k   <= k + 2'd1;
               if (k == 2'd3) begin
                  out <= sum;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Status flags come straight from the state register so no input
   // can reach an output combinationally.
   assign done = (state == DONE);
   assign busy = (state != IDLE);

endmodule
